tt_decode_seq: RTL and testbench

- Consumer side of the trap-type encoder handshake.
- Accepts a 3-bit trap index from the encoder, decodes it to the 8-bit SPARC tt field and a one-hot acknowledge that clears the matching pending request.
- Sequences trap entry: clear ET, save PC, save nPC, redirect fetch to the TBR address.
- Sits between the trap-index encoder and the PSR/register-file/fetch control in the datapath.

---
 rtl/tt_decode_seq.sv | 145 ++++++++++++++
 tb/tb_tt_decode_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_decode_seq.sv
// Trap-type decode and trap-entry sequencer: accepts a trap index from the
// encoder, acknowledges the source, and steps through clear-ET / save PC / save nPC / redirect.
module tt_decode_seq #(
  parameter int TBA_W = 20,
  parameter int NSRC  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic             et,
  input  logic [TBA_W-1:0] tba_in,
  output logic [7:0]       tt_out,
  output logic [31:0]      tbr_out,
  output logic [NSRC-1:0]  ack_onehot,
  output logic             et_clear,
  output logic             save_pc_we,
  output logic             save_npc_we,
  output logic             redirect,
  output logic             bad_code,
  output logic             error_mode,
  output logic             trap_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    SAVE_PC,
    SAVE_NPC,
    REDIRECT,
    ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       tt_nxt;
  logic             err_nxt;
  logic [NSRC-1:0]  ack_nxt;
  logic             et_clear_nxt;
  logic             save_pc_nxt;
  logic             save_npc_nxt;
  logic             redirect_nxt;
  logic             bad_nxt;
  logic             accept;
  logic             legal;

  // SPARC tt values for the six trap sources, in encoder priority order.
  function automatic logic [7:0] decode_tt(input logic [2:0] code);
    case (code)
      3'd0:    decode_tt = 8'h01;
      3'd1:    decode_tt = 8'h02;
      3'd2:    decode_tt = 8'h03;
      3'd3:    decode_tt = 8'h05;
      3'd4:    decode_tt = 8'h06;
      3'd5:    decode_tt = 8'h07;
      default: decode_tt = 8'h00;
    endcase
  endfunction

  assign code_ready = (state == IDLE);
  assign trap_busy  = (state == ENTER) || (state == SAVE_PC) ||
                      (state == SAVE_NPC) || (state == REDIRECT);
  assign accept     = code_valid & code_ready;
  assign legal      = (code_in <= 3'd5);
  assign tbr_out    = 32'({tba_in, tt_out, 4'b0000});

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_nxt    = state;
    tt_nxt       = tt_out;
    err_nxt      = error_mode;
    ack_nxt      = '0;
    et_clear_nxt = 1'b0;
    save_pc_nxt  = 1'b0;
    save_npc_nxt = 1'b0;
    redirect_nxt = 1'b0;
    bad_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            bad_nxt = 1'b1;
          end else begin
            tt_nxt = decode_tt(code_in);
            if (!et) begin
              // Trap with traps disabled: the processor halts in error mode.
              state_nxt = ERROR;
              err_nxt   = 1'b1;
            end else begin
              state_nxt    = ENTER;
              et_clear_nxt = 1'b1;
              ack_nxt      = NSRC'(1) << code_in;
            end
          end
        end
      end
      ENTER: begin
        state_nxt   = SAVE_PC;
        save_pc_nxt = 1'b1;
      end
      SAVE_PC: begin
        state_nxt    = SAVE_NPC;
        save_npc_nxt = 1'b1;
      end
      SAVE_NPC: begin
        state_nxt    = REDIRECT;
        redirect_nxt = 1'b1;
      end
      REDIRECT: state_nxt = IDLE;
      ERROR:    state_nxt = ERROR;
      default:  state_nxt = IDLE;
    endcase
  end

  // Pulses are registered alongside the state so each lines up with the
  // state it belongs to and is glitch-free for the downstream write enables.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state       <= IDLE;
      tt_out      <= 8'h00;
      error_mode  <= 1'b0;
      ack_onehot  <= '0;
      et_clear    <= 1'b0;
      save_pc_we  <= 1'b0;
      save_npc_we <= 1'b0;
      redirect    <= 1'b0;
      bad_code    <= 1'b0;
    end else begin
      state       <= state_nxt;
      tt_out      <= tt_nxt;
      error_mode  <= err_nxt;
      ack_onehot  <= ack_nxt;
      et_clear    <= et_clear_nxt;
      save_pc_we  <= save_pc_nxt;
      save_npc_we <= save_npc_nxt;
      redirect    <= redirect_nxt;
      bad_code    <= bad_nxt;
    end
  end

endmodule

// File: tb/tb_tt_decode_seq.sv
// Self-checking bench for tt_decode_seq: a cycle-age model of trap entry checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_tt_decode_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  code_in = 3'd0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        et = 1'b0;
  logic [19:0] tba_in = 20'h0;
  logic [7:0]  tt_out;
  logic [31:0] tbr_out;
  logic [5:0]  ack_onehot;
  logic        et_clear, save_pc_we, save_npc_we, redirect;
  logic        bad_code, error_mode, trap_busy;

  int checks = 0;
  int failures = 0;

  tt_decode_seq #(.TBA_W(20), .NSRC(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .et         (et),
    .tba_in     (tba_in),
    .tt_out     (tt_out),
    .tbr_out    (tbr_out),
    .ack_onehot (ack_onehot),
    .et_clear   (et_clear),
    .save_pc_we (save_pc_we),
    .save_npc_we(save_npc_we),
    .redirect   (redirect),
    .bad_code   (bad_code),
    .error_mode (error_mode),
    .trap_busy  (trap_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a trap is described by how many cycles ago it was accepted.
  // Age 1..4 maps to clear-ET, save PC, save nPC, redirect.
  logic [7:0] tt_tab [0:5] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07};
  bit         m_on = 1'b0;
  int         m_age = 0;
  logic [7:0] m_tt = 8'h00;
  bit         m_err = 1'b0;
  bit         m_bad = 1'b0;
  int         m_code = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_on = 1'b1; m_age = 0; m_tt = 8'h00; m_err = 1'b0; m_bad = 1'b0; m_code = 0;
    end else if (m_on) begin
      m_bad = 1'b0;
      if (m_age != 0) begin
        m_age = (m_age == 4) ? 0 : m_age + 1;
      end else if (!m_err && code_valid) begin
        if (code_in > 3'd5) begin
          m_bad = 1'b1;
        end else begin
          m_tt = tt_tab[code_in];
          if (!et) m_err = 1'b1;
          else begin
            m_age  = 1;
            m_code = int'(code_in);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("code_ready",  64'(code_ready),  64'(m_age == 0 && !m_err));
      check("trap_busy",   64'(trap_busy),   64'(m_age != 0));
      check("error_mode",  64'(error_mode),  64'(m_err));
      check("bad_code",    64'(bad_code),    64'(m_bad));
      check("tt_out",      64'(tt_out),      64'(m_tt));
      check("tbr_out",     64'(tbr_out),     64'({tba_in, m_tt, 4'h0}));
      check("ack_onehot",  64'(ack_onehot),  (m_age == 1) ? (64'd1 << m_code) : 64'd0);
      check("et_clear",    64'(et_clear),    64'(m_age == 1));
      check("save_pc_we",  64'(save_pc_we),  64'(m_age == 2));
      check("save_npc_we", 64'(save_npc_we), 64'(m_age == 3));
      check("redirect",    64'(redirect),    64'(m_age == 4));
      check("pulse_overlap",
            64'($countones({et_clear, save_pc_we, save_npc_we, redirect}) <= 1), 64'd1);
    end
  end

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int n;

  initial begin
    repeat (2) tick();
    check("rst_ready", 64'(code_ready), 64'd1);
    check("rst_tt",    64'(tt_out),     64'h00);
    check("rst_err",   64'(error_mode), 64'd0);
    check("rst_busy",  64'(trap_busy),  64'd0);
    check("rst_pulses",
          64'({ack_onehot, et_clear, save_pc_we, save_npc_we, redirect, bad_code}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Trap code 3 with ET set.
    code_in = 3'd3; code_valid = 1'b1; et = 1'b1; tba_in = 20'hABCDE;
    tick();
    code_valid = 1'b0;
    check("t1_ack",      64'(ack_onehot), 64'b001000);
    check("t1_etclr",    64'(et_clear),   64'd1);
    check("t1_tt",       64'(tt_out),     64'h05);
    check("t1_ready_lo", 64'(code_ready), 64'd0);
    tick();
    check("t1_savepc",   64'(save_pc_we), 64'd1);
    tick();
    check("t1_savenpc",  64'(save_npc_we), 64'd1);
    tick();
    check("t1_redirect", 64'(redirect),   64'd1);
    check("t1_tbr",      64'(tbr_out),    64'hABCDE050);
    tick();
    check("t1_ready_hi", 64'(code_ready), 64'd1);

    // Trap code 5, zero trap base.
    code_in = 3'd5; code_valid = 1'b1; tba_in = 20'h0;
    tick();
    code_valid = 1'b0;
    check("t2_tt",  64'(tt_out),     64'h07);
    check("t2_ack", 64'(ack_onehot), 64'b100000);
    check("t2_tbr", 64'(tbr_out),    64'h00000070);
    repeat (4) tick();

    // Illegal code 6.
    code_in = 3'd6; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check("t3_bad",   64'(bad_code),   64'd1);
    check("t3_tt",    64'(tt_out),     64'h07);
    check("t3_ack",   64'(ack_onehot), 64'd0);
    check("t3_ready", 64'(code_ready), 64'd1);
    tick();
    check("t3_bad_1cyc", 64'(bad_code), 64'd0);

    // Legal code with ET=0 enters error mode; later codes are ignored.
    code_in = 3'd1; code_valid = 1'b1; et = 1'b0;
    tick();
    code_in = 3'd3; et = 1'b1;
    check("t4_err",   64'(error_mode), 64'd1);
    check("t4_tt",    64'(tt_out),     64'h02);
    check("t4_ready", 64'(code_ready), 64'd0);
    check("t4_busy",  64'(trap_busy),  64'd0);
    check("t4_noclr", 64'(et_clear),   64'd0);
    repeat (3) tick();
    check("t4_sticky", 64'(error_mode), 64'd1);
    check("t4_noack",  64'(ack_onehot), 64'd0);
    // Reset with an acceptable code still presented: reset wins.
    reset_n = 1'b0;
    repeat (2) tick();
    check("t4_rst_err", 64'(error_mode), 64'd0);
    check("t4_rst_tt",  64'(tt_out),     64'h00);
    check("t4_rst_ack", 64'(ack_onehot), 64'd0);
    code_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Reset during SAVE_PC aborts the sequence.
    code_in = 3'd2; code_valid = 1'b1; et = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    check("t5_savepc", 64'(save_pc_we), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_npc",   64'(save_npc_we), 64'd0);
    check("t5_ready", 64'(code_ready),  64'd1);
    check("t5_tt",    64'(tt_out),      64'h00);
    tick();
    check("t5_noredir", 64'(redirect), 64'd0);
    tick();

    // Back-to-back traps with code_valid held.
    code_in = 3'd0; code_valid = 1'b1; et = 1'b1; tba_in = 20'h12345;
    tick();
    check("t6_ack0", 64'(ack_onehot), 64'b000001);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (redirect) code_in = 3'd4;
      if (ack_onehot != 6'd0) break;
    end
    code_valid = 1'b0;
    check("t6_gap",  64'(n),          64'd5);
    check("t6_ack4", 64'(ack_onehot), 64'b010000);
    check("t6_tt",   64'(tt_out),     64'h06);
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
